// File: rtl/tx_ctrl_pkg.sv
// tx_ctrl_pkg: shared state encoding and constants for the T=0 character repeat controller
package tx_ctrl_pkg;
   typedef enum logic [2:0] {IDLE, LOAD, WAIT_STOP, SAMPLE, WAIT_END, RECOVER, GUARD} txState_t;
   localparam int RECOVER_ETU = 2;
endpackage

// File: rtl/etu_timer.sv
// etu_timer: loadable down-counter in comClk ticks, optionally counting whole etus
// Ports: clk, nReset (async, active-low); tickEn advances the count; load captures
// loadEtus (etu mode, loadEtus x clocksPerBit ticks) or loadTicks when loadEtus is 0;
// expired is high on the tick that brings the count to zero.
module etu_timer #(
   parameter int CLOCK_PER_BIT_WIDTH = 13,
   parameter int GUARD_WIDTH = 8
) (
   input  logic clk,
   input  logic nReset,
   input  logic tickEn,
   input  logic load,
   input  logic [CLOCK_PER_BIT_WIDTH-1:0] loadTicks,
   input  logic [GUARD_WIDTH-1:0] loadEtus,
   input  logic [CLOCK_PER_BIT_WIDTH-1:0] clocksPerBit,
   output logic expired
);
   logic [CLOCK_PER_BIT_WIDTH-1:0] tickCnt;
   logic [GUARD_WIDTH-1:0] etuCnt;
   logic etuWrap;
   // tickCnt holds ticks left in the current etu, etuCnt the whole etus still to follow
   assign etuWrap = (tickCnt == CLOCK_PER_BIT_WIDTH'(1)) && (etuCnt != '0);
   assign expired = tickEn && (tickCnt == CLOCK_PER_BIT_WIDTH'(1)) && (etuCnt == '0);
   always_ff @(posedge clk or negedge nReset)
      if (!nReset) begin
         tickCnt <= '0;
         etuCnt <= '0;
      end else if (load) begin
         tickCnt <= (loadEtus == '0) ? loadTicks : clocksPerBit;
         etuCnt <= (loadEtus == '0) ? '0 : loadEtus - GUARD_WIDTH'(1);
      end else if (tickEn && tickCnt != '0) begin
         tickCnt <= etuWrap ? clocksPerBit : tickCnt - CLOCK_PER_BIT_WIDTH'(1);
         etuCnt <= etuWrap ? etuCnt - GUARD_WIDTH'(1) : etuCnt;
      end
endmodule

// File: rtl/tx_char_repeat_ctrl.sv
// tx_char_repeat_ctrl: sequences T=0 character transmission with error-signal retries and extra guard time
// Ports: host side byteIn/byteValid/byteReady; transmitter side txData/txLoad out,
// txFull/txRun/txStopBits in; ioIn is the synchronised line; busy/done/error/retryCount
// report character status; clocksPerBit/extraGuard/maxRetries configure timing and retries.
module tx_char_repeat_ctrl
   import tx_ctrl_pkg::*;
#(
   parameter int CLOCK_PER_BIT_WIDTH = 13,
   parameter int GUARD_WIDTH = 8,
   parameter int RETRY_WIDTH = 3
) (
   input  logic clk,
   input  logic nReset,
   input  logic comClkEn,
   input  logic [CLOCK_PER_BIT_WIDTH-1:0] clocksPerBit,
   input  logic [GUARD_WIDTH-1:0] extraGuard,
   input  logic [RETRY_WIDTH-1:0] maxRetries,
   input  logic [7:0] byteIn,
   input  logic byteValid,
   output logic byteReady,
   output logic [7:0] txData,
   output logic txLoad,
   input  logic txFull,
   input  logic txRun,
   input  logic txStopBits,
   input  logic ioIn,
   output logic busy,
   output logic done,
   output logic error,
   output logic [RETRY_WIDTH-1:0] retryCount
);
   txState_t state, nextState;
   logic stopPrev, errFlag, abortFlag;
   logic timerLoad, timerExpired;
   logic [CLOCK_PER_BIT_WIDTH-1:0] timerTicks;
   logic [GUARD_WIDTH-1:0] timerEtus;
   logic accept, sampleNow, endChar, retry, finishNow;
   assign byteReady = (state == IDLE);
   assign busy = (state != IDLE);
   assign accept = byteValid && byteReady;
   assign sampleNow = (state == SAMPLE) && timerExpired;
   assign endChar = (state == WAIT_END) && !txRun;
   assign retry = errFlag && (retryCount < maxRetries);
   // a zero guard skips GUARD entirely so done lands on the edge that sees txRun low
   assign finishNow = ((state == GUARD) && timerExpired) || (endChar && !retry && extraGuard == '0);
   assign timerTicks = clocksPerBit >> 1;
   etu_timer #(
      .CLOCK_PER_BIT_WIDTH(CLOCK_PER_BIT_WIDTH),
      .GUARD_WIDTH(GUARD_WIDTH)
   ) etuTimer (
      .clk(clk),
      .nReset(nReset),
      .tickEn(comClkEn),
      .load(timerLoad),
      .loadTicks(timerTicks),
      .loadEtus(timerEtus),
      .clocksPerBit(clocksPerBit),
      .expired(timerExpired)
   );
   always_comb begin
      nextState = state;
      timerLoad = 1'b0;
      timerEtus = '0;
      case (state)
         IDLE: nextState = accept ? LOAD : IDLE;
         LOAD: nextState = txFull ? WAIT_STOP : LOAD;
         WAIT_STOP:
            if (txStopBits && !stopPrev) begin
               nextState = (maxRetries == '0) ? WAIT_END : SAMPLE;
               timerLoad = 1'b1;
            end
         SAMPLE: nextState = timerExpired ? WAIT_END : SAMPLE;
         WAIT_END:
            if (!txRun) begin
               nextState = retry ? RECOVER : (extraGuard == '0) ? IDLE : GUARD;
               timerLoad = 1'b1;
               timerEtus = retry ? GUARD_WIDTH'(RECOVER_ETU) : extraGuard;
            end
         RECOVER: nextState = timerExpired ? LOAD : RECOVER;
         GUARD: nextState = timerExpired ? IDLE : GUARD;
         default: nextState = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge nReset)
      if (!nReset) begin
         state <= IDLE;
         stopPrev <= 1'b0;
         errFlag <= 1'b0;
         abortFlag <= 1'b0;
         txData <= '0;
         txLoad <= 1'b0;
         done <= 1'b0;
         error <= 1'b0;
         retryCount <= '0;
      end else begin
         state <= nextState;
         stopPrev <= txStopBits;
         // registered load drops on the same edge that leaves LOAD
         txLoad <= (nextState == LOAD);
         txData <= accept ? byteIn : txData;
         retryCount <= accept ? '0 : (endChar && retry) ? retryCount + RETRY_WIDTH'(1) : retryCount;
         errFlag <= sampleNow ? !ioIn : finishNow ? 1'b0 : errFlag;
         abortFlag <= finishNow ? 1'b0 : (endChar && errFlag && !retry) ? 1'b1 : abortFlag;
         done <= finishNow;
         error <= finishNow && (abortFlag || errFlag);
      end
endmodule

// File: tb/tb_tx_char_repeat_ctrl.sv
// tb_tx_char_repeat_ctrl: directed and randomized checks of the repeat controller against a transaction-level model
module tb_tx_char_repeat_ctrl;
   logic clk = 1'b0;
   logic nReset = 1'b0;
   logic comClkEn = 1'b1;
   logic [12:0] clocksPerBit = 13'd372;
   logic [7:0] extraGuard = 8'd2;
   logic [2:0] maxRetries = 3'd3;
   logic [7:0] byteIn = 8'h00;
   logic byteValid = 1'b0;
   logic byteReady;
   logic [7:0] txData;
   logic txLoad;
   logic txFull = 1'b0;
   logic txRun = 1'b0;
   logic txStopBits = 1'b0;
   logic ioIn = 1'b1;
   logic busy, done, error;
   logic [2:0] retryCount;

   int nAsserts = 0;
   int nFail = 0;
   longint cyc = 0;
   int cpb = 372;
   bit gateTicks = 1'b0;
   int nackLeft = 0;
   longint runFall[$];
   longint loadRise[$];
   longint doneCyc[$];
   logic doneErr[$];
   logic [2:0] doneRetry[$];
   logic [7:0] sentBytes[$];

   tx_char_repeat_ctrl dut (
      .clk(clk), .nReset(nReset), .comClkEn(comClkEn), .clocksPerBit(clocksPerBit),
      .extraGuard(extraGuard), .maxRetries(maxRetries), .byteIn(byteIn), .byteValid(byteValid),
      .byteReady(byteReady), .txData(txData), .txLoad(txLoad), .txFull(txFull), .txRun(txRun),
      .txStopBits(txStopBits), .ioIn(ioIn), .busy(busy), .done(done), .error(error),
      .retryCount(retryCount)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial forever begin
      @(negedge clk);
      comClkEn = gateTicks ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   logic loadPrev = 1'b0;
   initial forever begin
      @(negedge clk);
      if (done) begin
         doneCyc.push_back(cyc);
         doneErr.push_back(error);
         doneRetry.push_back(retryCount);
      end
      if (txLoad && !loadPrev) loadRise.push_back(cyc);
      loadPrev = txLoad;
   end

   task automatic ticks(input int n);
      int i;
      i = 0;
      while (i < n && nReset) begin
         @(posedge clk);
         if (comClkEn) i++;
      end
   endtask

   // Transmitter/card model: 1 start + 9 data/parity etu, then 2 stop etu during which a
   // receiver that rejects this copy pulls the line low.
   initial forever begin
      bit nack;
      @(posedge clk);
      if (nReset && txLoad && !txFull) begin
         nack = (nackLeft > 0);
         if (nack) nackLeft--;
         sentBytes.push_back(txData);
         #1 txFull = 1'b1; txRun = 1'b1;
         ticks(cpb);
         #1 txFull = 1'b0;
         ticks(9 * cpb);
         #1 txStopBits = 1'b1; ioIn = !nack;
         ticks(2 * cpb);
         #1 txStopBits = 1'b0; ioIn = 1'b1; txRun = 1'b0; txFull = 1'b0;
         if (nReset) runFall.push_back(cyc);
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nAsserts++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clearLogs();
      runFall.delete(); loadRise.delete(); doneCyc.delete();
      doneErr.delete(); doneRetry.delete(); sentBytes.delete();
   endtask

   task automatic waitDone(input string tag);
      longint t0;
      t0 = cyc;
      while (!done && cyc - t0 < 60000) @(negedge clk);
      check({tag, "_done_seen"}, done, 1'b1);
   endtask

   // Expected outcome from the retry rules: copies rejected up to maxRetries are resent,
   // one more rejection aborts; maxRetries==0 never looks at the line.
   task automatic runChar(input logic [7:0] b, input int nNack, input int c, input int g,
                          input int m, input bit gate);
      int expTx;
      bit expErr;
      @(negedge clk);
      cpb = c; gateTicks = gate; nackLeft = nNack;
      clocksPerBit = 13'(c); extraGuard = 8'(g); maxRetries = 3'(m);
      clearLogs();
      expTx = (m == 0) ? 1 : (nNack > m) ? m + 1 : nNack + 1;
      expErr = (m != 0) && (nNack > m);
      byteIn = b; byteValid = 1'b1;
      @(negedge clk);
      byteValid = 1'b0;
      waitDone("char");
      repeat (3) @(negedge clk);
      check("done_pulses", doneCyc.size(), 1);
      check("tx_count", sentBytes.size(), expTx);
      check("load_bursts", loadRise.size(), expTx);
      foreach (sentBytes[i]) check("tx_byte", sentBytes[i], b);
      if (doneCyc.size() > 0) begin
         check("done_error", doneErr[0], expErr);
         check("done_retry", doneRetry[0], 3'(expTx - 1));
      end
      check("ready_after", byteReady, 1'b1);
      check("busy_after", busy, 1'b0);
      // done rises g etu after the first edge that sees txRun low; a resend starts 2 etu after it
      if (!gate && doneCyc.size() > 0 && runFall.size() == expTx) begin
         check("guard_time", doneCyc[0] - runFall[expTx-1] - 1, 64'(g * c));
         for (int i = 1; i < loadRise.size() && i < runFall.size(); i++)
            check("recover_time", loadRise[i] - runFall[i-1] - 1, 64'(2 * c));
      end
   endtask

   initial begin
      #2;
      check("rst_txLoad", txLoad, 1'b0);
      check("rst_txData", txData, 8'h00);
      check("rst_done", done, 1'b0);
      check("rst_error", error, 1'b0);
      check("rst_retry", retryCount, 3'd0);
      check("rst_busy", busy, 1'b0);
      repeat (2) @(negedge clk);
      nReset = 1'b1;
      @(negedge clk);
      check("rst_ready", byteReady, 1'b1);

      runChar(8'h3B, 0, 372, 2, 3, 1'b0);
      runChar(8'h3B, 1, 372, 2, 3, 1'b0);
      runChar(8'h3B, 4, 372, 2, 3, 1'b0);
      runChar(8'h3B, 1, 20, 2, 0, 1'b0);
      runChar(8'h71, 0, 16, 0, 2, 1'b0);

      // back-to-back with byteValid held high
      @(negedge clk);
      cpb = 16; gateTicks = 1'b0; nackLeft = 0;
      clocksPerBit = 13'd16; extraGuard = 8'd1; maxRetries = 3'd3;
      clearLogs();
      byteIn = 8'hA5; byteValid = 1'b1;
      @(negedge clk);
      check("b2b_first_data", txData, 8'hA5);
      waitDone("b2b_first");
      check("b2b_ignored_count", sentBytes.size(), 1);
      check("b2b_data_stable", txData, 8'hA5);
      byteIn = 8'h5A;
      @(negedge clk);
      check("b2b_second_data", txData, 8'h5A);
      check("b2b_second_busy", busy, 1'b1);
      byteValid = 1'b0;
      waitDone("b2b_second");
      check("b2b_total", sentBytes.size(), 2);
      if (sentBytes.size() == 2) check("b2b_second_byte", sentBytes[1], 8'h5A);

      // reset in the data bits of the repeated copy
      repeat (2) @(negedge clk);
      cpb = 24; nackLeft = 1;
      clocksPerBit = 13'd24; extraGuard = 8'd1; maxRetries = 3'd3;
      clearLogs();
      byteIn = 8'hC3; byteValid = 1'b1;
      @(negedge clk);
      byteValid = 1'b0;
      for (int i = 0; i < 5000 && sentBytes.size() < 2; i++) @(negedge clk);
      check("rst_mid_second_copy", sentBytes.size(), 2);
      repeat (3 * 24) @(negedge clk);
      check("rst_mid_retry_before", retryCount, 3'd1);
      nReset = 1'b0;
      #1;
      check("rst_mid_txLoad", txLoad, 1'b0);
      check("rst_mid_busy", busy, 1'b0);
      check("rst_mid_ready", byteReady, 1'b1);
      check("rst_mid_retry", retryCount, 3'd0);
      @(negedge clk);
      nackLeft = 0;
      nReset = 1'b1;
      repeat (3) @(negedge clk);
      runChar(8'h96, 0, 24, 1, 3, 1'b0);

      for (int k = 0; k < 8; k++)
         runChar(8'($urandom), int'($urandom_range(0, 4)), int'($urandom_range(4, 24)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
      $finish;
   end
endmodule
